// File: rtl/key_debouncer.sv
// Purpose : debounce N active-low async push-buttons into clean levels plus press/release pulses.
// Latency : raw edge sampled at clock k -> pressed/pulse registered after edge k+TICKS+1.
// Backpressure: none; pulses are single-cycle strobes that consumers must catch when they fire.
// Optional feature: define KEY_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debouncer #(
    parameter int F            = 50_000_000,
    parameter int N            = 2,
    parameter int MS           = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_MS    = 100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] pressed,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse
);

    // F/1000 first keeps the products inside 32 bits for realistic clock rates.
    localparam int TICKS   = F / 1000 * MS;
    localparam int CW      = $clog2(TICKS + 1);
    localparam int RPT_DLY = F / 1000 * REPEAT_DELAY;
    localparam int RPT_PER = F / 1000 * REPEAT_MS;

    // The repeat counter reloads to RPT_DLY-RPT_PER, so the first delay may not be shorter
    // than the period; a nonsensical configuration yields an inert block.
    localparam bit CFG_OK  = (TICKS >= 1) && (RPT_PER >= 1) && (RPT_DLY >= RPT_PER);

    generate
        if (CFG_OK) begin : g_cfg_ok
            for (genvar i = 0; i < N; i++) begin : g_key
                logic          sync1_q, sync1_d;
                logic          sync2_q, sync2_d;
                logic          pressed_q, pressed_d;
                logic          press_q, press_d;
                logic          release_q, release_d;
                logic [CW-1:0] cnt_q, cnt_d;
                logic          s;
`ifdef KEY_REPEAT_EN
                localparam int RW = $clog2(RPT_DLY + 1);
                logic [RW-1:0] rcnt_q, rcnt_d;
`endif

                // Next-state: synchronizer shift, stability count, level update and pulses.
                always_comb begin
                    sync1_d   = key[i];
                    sync2_d   = sync1_q;
                    s         = ~sync2_q;
                    pressed_d = pressed_q;
                    press_d   = 1'b0;
                    release_d = 1'b0;
                    cnt_d     = '0;
                    // Any cycle agreeing with the current level leaves cnt at 0 (glitch reject).
                    if (s != pressed_q) begin
                        if (cnt_q == CW'(TICKS - 1)) begin
                            pressed_d = s;
                            press_d   = s;
                            release_d = ~s;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`ifdef KEY_REPEAT_EN
                    // Repeat timer runs only while held and not being released this cycle;
                    // the press event itself sees pressed_q=0 and therefore clears it.
                    rcnt_d = '0;
                    if (pressed_q && pressed_d) begin
                        if (rcnt_q == RW'(RPT_DLY - 1)) begin
                            press_d = 1'b1;
                            rcnt_d  = RW'(RPT_DLY - RPT_PER);
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
`else
                    // Without auto-repeat, press_pulse comes only from the debounce event.
`endif
                end

                // State registers; sync flops reset to the released (high) pin level.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        sync1_q   <= 1'b1;
                        sync2_q   <= 1'b1;
                        pressed_q <= 1'b0;
                        press_q   <= 1'b0;
                        release_q <= 1'b0;
                        cnt_q     <= '0;
`ifdef KEY_REPEAT_EN
                        rcnt_q    <= '0;
`endif
                    end else begin
                        sync1_q   <= sync1_d;
                        sync2_q   <= sync2_d;
                        pressed_q <= pressed_d;
                        press_q   <= press_d;
                        release_q <= release_d;
                        cnt_q     <= cnt_d;
`ifdef KEY_REPEAT_EN
                        rcnt_q    <= rcnt_d;
`endif
                    end
                end

                assign pressed[i]       = pressed_q;
                assign press_pulse[i]   = press_q;
                assign release_pulse[i] = release_q;
            end
        end else begin : g_cfg_bad
            assign pressed       = '0;
            assign press_pulse   = '0;
            assign release_pulse = '0;
        end
    endgenerate

endmodule
